uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
// - UART 8N1 serialiser: start bit (0), 8 data bits LSB first, one stop bit (1).
// - A small input FIFO decouples the APB-side byte producer from the serial line.
// - Counterpart of the team's UART receiver.
// - Sits between the APB slave register file (byte source) and the board TX pin.
// PARAMETERS
// - CLKS_PER_BIT   868   clk cycles per serial bit (100 MHz / 115200); legal >= 2
// - FIFO_DEPTH     4     input FIFO entries; power of 2, >= 2
// PORTS
// - clk        in   1  system clock; all logic on posedge
// - rst        in   1  asynchronous, active-high reset
// - din        in   8  byte to transmit; sampled only on handshake
// - din_valid  in   1  producer has a byte on din
// - din_ready  out  1  FIFO can accept a byte (= !fifo_full)
// - tx         out  1  serial line, registered, idles high
// - busy       out  1  frame in progress or FIFO non-empty
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
// - Reset values: tx=1, busy=0, state=IDLE, counters=0, FIFO empty, din_ready=1.
// - Handshake:
//   - A byte is accepted on any posedge with din_valid && din_ready.
//   - din_ready depends only on FIFO fullness, never on din_valid.
//   - A byte offered while full is not taken; the producer holds it.
// - State machine, 4 states: IDLE, START, DATA, STOP.
//   - IDLE: tx=1. If FIFO non-empty: pop to an 8-bit shift register, tx<=0, go START.
//   - START: hold tx=0 for exactly CLKS_PER_BIT clks. Then tx<=shift[0], bit_idx=0, go DATA.
//   - DATA: each bit held CLKS_PER_BIT clks, then shift right, bit_idx+1.
//     After bit 7: tx<=1, go STOP.
//   - STOP: hold tx=1 for CLKS_PER_BIT clks. At the end:
//     - FIFO non-empty: pop, tx<=0, go START. Back-to-back, no idle gap.
//     - Otherwise go IDLE.
// - Timing:
//   - Bit counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps.
//   - Frame length is exactly 10*CLKS_PER_BIT clks.
//   - Latency: byte accepted at edge k into an empty FIFO while IDLE -> tx falls at edge k+1.
// - Boundary conditions:
//   - A push and an STOP->START pop in the same cycle are both honoured.
//     FIFO count is unchanged; din_ready stays as computed from the pre-edge full flag.
//   - Full FIFO: din_ready=0 until the next pop. The next pop occurs at most one frame later.
//   - Empty FIFO at frame end: go IDLE with tx=1.
//   - Pointer wrap-around is handled by power-of-2 indexing with an extra MSB for full/empty.
//   - Reset mid-frame: tx goes to 1 asynchronously; the current frame and all FIFO
//     contents are discarded.
//   - busy = (state != IDLE) | !fifo_empty. Registered; deasserts the cycle IDLE is
//     entered with the FIFO empty.
//   - din and din_valid are ignored when no handshake occurs; no X propagation to tx.
// STRUCTURE
// - Shared package/include: UART state encodings (IDLE/START/DATA/STOP), shared with
//   the receiver; default CLKS_PER_BIT constant 868.
// - One sub-module: sync_fifo.
//   - Parameters: WIDTH=8, DEPTH=FIFO_DEPTH.
//   - Ports: clk, rst, push, pop, wdata, rdata (show-ahead), full, empty.
// - Top-level contents: FSM, bit counter, bit index, shift register, tx register.
// TESTING (benches use CLKS_PER_BIT=8)
// - Reset: assert rst for 3 clks -> tx=1, busy=0, din_ready=1. Release -> tx stays 1, no frame.
// - Single byte 0x55: accepted at edge k.
//   - tx=0 during clks k+1..k+8.
//   - Then bits 1,0,1,0,1,0,1,0, 8 clks each.
//   - Then stop=1 for 8 clks; busy falls at k+81.
// - Back-to-back: push 0xA5, 0x3C, 0xFF, 0x00, 0x81 on consecutive clks.
//   - First 5 accepted: one goes straight to the shift register, 4 fill the FIFO.
//   - 6th offer sees din_ready=0.
//   - Five frames emitted contiguously, 400 clks total, no idle bit between them.
// - Reset mid-frame: rst during DATA bit 3 of 0xC3, with 2 bytes queued.
//   - tx=1 within the reset cycle (async); FIFO empty; nothing transmitted after release.
// - Loopback into the team receiver (same CLKS_PER_BIT): random 256 bytes, random
//   din_valid gaps -> every byte received in order; valid pulses once per byte.
// - Push on the STOP->START pop cycle with the FIFO full -> no byte lost or duplicated;
//   scoreboard order preserved.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encodings used by both the transmitter
// and the receiver, plus default timing constants.
package uart_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

endpackage

// File: rtl/uart_transmitter_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data. Pointers carry one extra
// MSB so full and empty are distinguishable when the index bits match.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Requests against a full/empty FIFO are ignored rather than corrupting state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer update; reset discards all contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter: input FIFO feeding a start/8-data/stop serialiser.
//
// Byte input handshake: a byte on din is taken on any rising clk edge where
// din_valid && din_ready. din_ready reflects only FIFO fullness and never
// depends on din_valid; a producer whose byte is not taken holds it.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    idx_q, idx_n;
  logic [7:0]    shift_q, shift_n;
  logic          tx_n;
  logic          busy_n;
  logic          push;
  logic          pop;
  logic          bit_done;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  assign din_ready = !fifo_full;
  assign push      = din_valid && !fifo_full;
  assign bit_done  = (cnt_q == CNT_LAST);
  assign state_dbg = state_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and datapath: each bit period is CLKS_PER_BIT clocks; the end
  // of STOP chains straight into the next START when a byte is waiting.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    tx_n    = tx;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_rdata;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          tx_n    = shift_q[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n = '0;
          if (idx_q == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            // Next bit is shift[1] now; after the shift it sits in shift[0].
            shift_n = {1'b0, shift_q[7:1]};
            tx_n    = shift_q[1];
            idx_n   = idx_q + 3'd1;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_rdata;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Busy looks at post-edge conditions. Pops only happen on the way into
  // START, so when the next state is IDLE the FIFO is non-empty afterwards
  // exactly when it already was or a byte is being pushed now.
  always_comb begin
    busy_n = (state_n != IDLE) || !fifo_empty || push;
  end

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter with CLKS_PER_BIT=8, FIFO_DEPTH=4.
module tb_uart_transmitter;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_count = 0;
  bit mon_en   = 1'b0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop
  } vec_t;

  vec_t vecs[7];

  uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tx        (tx),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", busy, 1'b0);
  endtask

  // Receiver model: finds a start edge, samples mid-bit, checks framing and
  // compares the recovered byte with the oldest accepted byte.
  initial begin
    logic [7:0] got;
    forever begin
      tick();
      if (mon_en && tx === 1'b0) begin
        repeat (CPB / 2 - 1) tick();
        check("mon_start_bit", tx, 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) tick();
          got[b] = tx;
        end
        repeat (CPB) tick();
        check("mon_stop_bit", tx, 1'b1);
        if (exp_q.size() == 0) begin
          check("mon_unexpected_byte", {24'h0, got}, 32'hFFFF_FFFF);
        end else begin
          check("mon_byte", {24'h0, got}, {24'h0, exp_q.pop_front()});
        end
        rx_count++;
        repeat (CPB / 2 - 1) tick();
      end
    end
  end

  // Driver: one byte into an idle transmitter, then check every clock of the frame.
  task automatic send_single(input vec_t v);
    din       = v.data;
    din_valid = 1'b1;
    check("single_ready", din_ready, 1'b1);
    tick();
    din_valid = 1'b0;
    din       = 8'($urandom);
    check("single_tx_at_accept", tx, 1'b1);
    check("single_busy_at_accept", busy, 1'b1);
    for (int j = 1; j <= FRAME; j++) begin
      tick();
      check("single_frame_bit", tx, v.frame[(j - 1) / CPB]);
    end
    check("single_busy_last", busy, 1'b1);
    tick();
    check("single_busy_fall", busy, 1'b0);
    check("single_tx_idle", tx, 1'b1);
  endtask

  initial begin
    logic stream[$];
    int   n;
    int   accepted;

    vecs[0] = '{8'h55, 10'b1_01010101_0};
    vecs[1] = '{8'hA5, 10'b1_10100101_0};
    vecs[2] = '{8'h3C, 10'b1_00111100_0};
    vecs[3] = '{8'hFF, 10'b1_11111111_0};
    vecs[4] = '{8'h00, 10'b1_00000000_0};
    vecs[5] = '{8'h81, 10'b1_10000001_0};
    vecs[6] = '{8'hC3, 10'b1_11000011_0};

    // Reset for 3 clocks
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", din_ready, 1'b1);
    check("reset_state", state_dbg, 2'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("post_reset_tx", tx, 1'b1);
      check("post_reset_busy", busy, 1'b0);
    end

    // Table of single frames
    for (int i = 0; i < 7; i++) begin
      send_single(vecs[i]);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Back-to-back: five bytes on consecutive clocks, sixth offer refused
    for (int i = 1; i <= 5; i++)
      for (int b = 0; b < 10; b++)
        for (int r = 0; r < CPB; r++)
          stream.push_back(vecs[i].frame[b]);
    din       = vecs[1].data;
    din_valid = 1'b1;
    check("b2b_ready_first", din_ready, 1'b1);
    for (int c = 0; c <= 5 * FRAME; c++) begin
      tick();
      if (c < 4) begin
        din = vecs[c + 2].data;
        check("b2b_ready_fill", din_ready, 1'b1);
      end else if (c == 4) begin
        din = 8'h77;
        check("b2b_ready_full", din_ready, 1'b0);
      end else if (c == 5) begin
        check("b2b_ready_held_low", din_ready, 1'b0);
        din_valid = 1'b0;
      end
      if (c == FRAME)     check("b2b_ready_before_pop", din_ready, 1'b0);
      if (c == FRAME + 1) check("b2b_ready_after_pop", din_ready, 1'b1);
      if (c == 0) check("b2b_tx_at_accept", tx, 1'b1);
      else        check("b2b_stream_bit", tx, stream[c - 1]);
    end
    tick();
    check("b2b_busy_fall", busy, 1'b0);
    check("b2b_tx_idle", tx, 1'b1);

    // Producer holds din_valid continuously: pushes land against a full FIFO
    // and right after each frame-boundary pop.
    mon_en   = 1'b1;
    rx_count = 0;
    accepted = 0;
    din      = 8'($urandom);
    din_valid = 1'b1;
    n = 0;
    while (accepted < 10 && n < 5000) begin
      if (din_valid && din_ready) begin
        exp_q.push_back(din);
        accepted++;
        tick();
        din = 8'($urandom);
      end else begin
        tick();
      end
      n++;
    end
    din_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20 * FRAME) begin
      tick();
      n++;
    end
    check("stream_drained", exp_q.size(), 0);
    wait_idle(2 * FRAME);
    check("stream_rx_count", rx_count, 10);

    // Random bytes with random valid gaps
    rx_count = 0;
    accepted = 0;
    n = 0;
    while (accepted < 256 && n < 60000) begin
      din_valid = ($urandom_range(0, 3) != 0);
      din       = 8'($urandom);
      if (din_valid && din_ready) begin
        exp_q.push_back(din);
        accepted++;
      end
      tick();
      n++;
    end
    din_valid = 1'b0;
    check("random_all_offered", accepted, 256);
    n = 0;
    while (exp_q.size() != 0 && n < 20 * FRAME) begin
      tick();
      n++;
    end
    check("random_drained", exp_q.size(), 0);
    wait_idle(2 * FRAME);
    check("random_rx_count", rx_count, 256);
    mon_en = 1'b0;
    repeat (FRAME) tick();

    // Reset during DATA bit 3 of 0xC3 with two bytes queued
    din       = 8'hC3;
    din_valid = 1'b1;
    tick();
    din = 8'h11;
    tick();
    din = 8'h22;
    tick();
    din_valid = 1'b0;
    repeat (32) tick();
    check("midreset_bit3_low", tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_tx_async", tx, 1'b1);
    check("midreset_busy_async", busy, 1'b0);
    check("midreset_ready_async", din_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_state", state_dbg, 2'd0);
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      check("midreset_tx_quiet", tx, 1'b1);
      check("midreset_busy_quiet", busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
